vrf_banked_ff: RTL and testbench

// Flop-based, parametrised vector register file for one vector lane cluster. Storage is REG_NUM regs x ELEMS elements.
// A sequential operand-capture FSM reads 1..3 source operands (A, B, C), one per cycle, into operand buffers.

---
 rtl/vrf_banked_ff_if.sv | 45 ++++
 rtl/vrf_banked_ff.sv | 161 ++++++++++++++++
 tb/tb_vrf_banked_ff.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/vrf_banked_ff_if.sv
// Issue/sequencer <-> vector register file bundle: operand-capture request,
// operand read-out, element write beats and the v0 mask tap.
interface vrf_banked_ff_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int ELEMS      = 4
);
    localparam int ADDR_B = $clog2(REG_NUM);
    localparam int ELEM_B = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;

    logic                  rd_req_i;
    logic [1:0]            rd_nops_i;
    logic [ADDR_B-1:0]     a_addr_i;
    logic [ADDR_B-1:0]     b_addr_i;
    logic [ADDR_B-1:0]     c_addr_i;
    logic                  rd_busy_o;
    logic                  rd_op_ready_o;
    logic [ELEM_B-1:0]     rd_elem_i;
    logic [DATA_WIDTH-1:0] a_rdata_o;
    logic [DATA_WIDTH-1:0] b_rdata_o;
    logic [DATA_WIDTH-1:0] c_rdata_o;
    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [ADDR_B-1:0]     wr_addr_i;
    logic [ELEM_B-1:0]     wr_elem_i;
    logic [BE_W-1:0]       wr_be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  is_mask_used_i;
    logic [DATA_WIDTH-1:0] mask_rdata_o;

    modport master (
        output rd_req_i, rd_nops_i, a_addr_i, b_addr_i, c_addr_i, rd_elem_i,
               wr_valid_i, wr_addr_i, wr_elem_i, wr_be_i, wdata_i, is_mask_used_i,
        input  rd_busy_o, rd_op_ready_o, a_rdata_o, b_rdata_o, c_rdata_o,
               wr_ready_o, mask_rdata_o
    );

    modport slave (
        input  rd_req_i, rd_nops_i, a_addr_i, b_addr_i, c_addr_i, rd_elem_i,
               wr_valid_i, wr_addr_i, wr_elem_i, wr_be_i, wdata_i, is_mask_used_i,
        output rd_busy_o, rd_op_ready_o, a_rdata_o, b_rdata_o, c_rdata_o,
               wr_ready_o, mask_rdata_o
    );
endinterface

// File: rtl/vrf_banked_ff.sv
// Flop-based vector register file: sequential A/B/C operand capture into
// buffers, byte-enabled element writes with hazard hold-off, v0[0] mask shadow.
module vrf_banked_ff #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int ELEMS      = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    vrf_banked_ff_if.slave   bus
);
    localparam int ADDR_B = $clog2(REG_NUM);
    localparam int ELEM_B = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam logic [ADDR_B:0] REG_LIM  = (ADDR_B + 1)'(REG_NUM);
    localparam logic [ELEM_B:0] ELEM_LIM = (ELEM_B + 1)'(ELEMS);

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        CAP_A   = 3'd1,
        CAP_B   = 3'd2,
        CAP_C   = 3'd3,
        RD_DONE = 3'd4
    } rd_state_e;

    function automatic logic addr_ok(input logic [ADDR_B-1:0] a);
        return ({1'b0, a} < REG_LIM);
    endfunction

    function automatic logic elem_ok(input logic [ELEM_B-1:0] e);
        return ({1'b0, e} < ELEM_LIM);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [BE_W-1:0]       be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q   [REG_NUM][ELEMS];
    logic [DATA_WIDTH-1:0] buf_a_q [ELEMS];
    logic [DATA_WIDTH-1:0] buf_b_q [ELEMS];
    logic [DATA_WIDTH-1:0] buf_c_q [ELEMS];
    logic [DATA_WIDTH-1:0] mask_q;
    rd_state_e             state_q, state_d;
    logic [1:0]            nops_q;
    logic [ADDR_B-1:0]     a_addr_q, b_addr_q, c_addr_q;
    logic                  busy_q, ready_q;
    logic                  hold_s, wr_fire_s, wr_ok_s;

    // Next read state; operand count is already normalised to 1..3 in nops_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: begin
                if (bus.rd_req_i) state_d = CAP_A;
                else              state_d = RD_IDLE;
            end
            CAP_A:   state_d = (nops_q >= 2'd2) ? CAP_B : RD_DONE;
            CAP_B:   state_d = (nops_q == 2'd3) ? CAP_C : RD_DONE;
            CAP_C:   state_d = RD_DONE;
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // Operand-capture FSM with its buffers and registered status outputs.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= RD_IDLE;
            nops_q   <= 2'd1;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            for (int e = 0; e < ELEMS; e++) begin
                buf_a_q[e] <= '0;
                buf_b_q[e] <= '0;
                buf_c_q[e] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != RD_IDLE);
            ready_q <= (state_d == RD_DONE);
            case (state_q)
                RD_IDLE: begin
                    if (bus.rd_req_i) begin
                        nops_q   <= (bus.rd_nops_i == 2'd0) ? 2'd1 : bus.rd_nops_i;
                        a_addr_q <= bus.a_addr_i;
                        b_addr_q <= bus.b_addr_i;
                        c_addr_q <= bus.c_addr_i;
                    end
                end
                CAP_A: begin
                    for (int e = 0; e < ELEMS; e++)
                        buf_a_q[e] <= addr_ok(a_addr_q) ? mem_q[a_addr_q][e] : '0;
                end
                CAP_B: begin
                    for (int e = 0; e < ELEMS; e++)
                        buf_b_q[e] <= addr_ok(b_addr_q) ? mem_q[b_addr_q][e] : '0;
                end
                CAP_C: begin
                    for (int e = 0; e < ELEMS; e++)
                        buf_c_q[e] <= addr_ok(c_addr_q) ? mem_q[c_addr_q][e] : '0;
                end
                default: ;
            endcase
        end
    end

    // Writes stall only against operands still waiting to be captured.
    always_comb begin
        hold_s = 1'b0;
        case (state_q)
            CAP_A: hold_s = (bus.wr_addr_i == a_addr_q)
                          | ((nops_q >= 2'd2) & (bus.wr_addr_i == b_addr_q))
                          | ((nops_q == 2'd3) & (bus.wr_addr_i == c_addr_q));
            CAP_B: hold_s = (bus.wr_addr_i == b_addr_q)
                          | ((nops_q == 2'd3) & (bus.wr_addr_i == c_addr_q));
            CAP_C: hold_s = (bus.wr_addr_i == c_addr_q);
            default: hold_s = 1'b0;
        endcase
    end

    assign wr_fire_s = bus.wr_valid_i & ~hold_s;
    assign wr_ok_s   = addr_ok(bus.wr_addr_i) & elem_ok(bus.wr_elem_i);

    // Register storage and mask shadow; out-of-range beats are accepted and dropped.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mask_q <= '0;
            for (int r = 0; r < REG_NUM; r++)
                for (int e = 0; e < ELEMS; e++)
                    mem_q[r][e] <= '0;
        end else if (wr_fire_s && wr_ok_s) begin
            mem_q[bus.wr_addr_i][bus.wr_elem_i] <=
                merge_bytes(mem_q[bus.wr_addr_i][bus.wr_elem_i], bus.wdata_i, bus.wr_be_i);
            if ((bus.wr_addr_i == '0) && (bus.wr_elem_i == '0)) begin
                mask_q <= merge_bytes(mask_q, bus.wdata_i, bus.wr_be_i);
            end
        end
    end

    assign bus.rd_busy_o     = busy_q;
    assign bus.rd_op_ready_o = ready_q;
    assign bus.wr_ready_o    = ~hold_s;
    assign bus.a_rdata_o     = elem_ok(bus.rd_elem_i) ? buf_a_q[bus.rd_elem_i] : '0;
    assign bus.b_rdata_o     = elem_ok(bus.rd_elem_i) ? buf_b_q[bus.rd_elem_i] : '0;
    assign bus.c_rdata_o     = elem_ok(bus.rd_elem_i) ? buf_c_q[bus.rd_elem_i] : '0;
    assign bus.mask_rdata_o  = bus.is_mask_used_i ? mask_q : '0;
endmodule

// File: tb/tb_vrf_banked_ff.sv
// Self-checking bench for vrf_banked_ff: directed scenarios plus randomized
// traffic compared every cycle against a snapshot-based reference model.
module tb_vrf_banked_ff;
    localparam int DW = 32;
    localparam int RN = 32;
    localparam int NE = 4;

    logic clk_i = 1'b0;
    logic resetn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    vrf_banked_ff_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .ELEMS(NE)) bus();
    vrf_banked_ff #(.DATA_WIDTH(DW), .REG_NUM(RN), .ELEMS(NE)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: storage, buffers, and the register contents frozen at request accept.
    logic [31:0] m_mem  [RN][NE];
    logic [31:0] m_buf  [3][NE];
    logic [31:0] m_snap [3][NE];
    logic [31:0] m_mask;
    bit          m_active;
    int          m_k, m_nops;
    int          m_addr [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < RN; r++) for (int e = 0; e < NE; e++) m_mem[r][e] = 32'h0;
        for (int i = 0; i < 3; i++) for (int e = 0; e < NE; e++) begin
            m_buf[i][e] = 32'h0; m_snap[i][e] = 32'h0;
        end
        m_mask = 32'h0; m_active = 1'b0; m_k = 0; m_nops = 1;
    endtask

    function automatic bit exp_wr_ready();
        if (m_active) begin
            for (int i = m_k; i < m_nops; i++)
                if (m_addr[i] == int'(bus.wr_addr_i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        bus.rd_req_i = 1'b0; bus.rd_nops_i = 2'd0;
        bus.a_addr_i = '0; bus.b_addr_i = '0; bus.c_addr_i = '0;
        bus.rd_elem_i = '0; bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0;
        bus.wr_elem_i = '0; bus.wr_be_i = '0; bus.wdata_i = 32'h0;
        bus.is_mask_used_i = 1'b1;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        bit wfire, acc, wr_rdy;
        int wa, we, nn;
        @(negedge clk_i); #1;
        wr_rdy = exp_wr_ready();
        check_eq("busy",     {31'h0, bus.rd_busy_o},     {31'h0, m_active});
        check_eq("op_ready", {31'h0, bus.rd_op_ready_o}, {31'h0, (m_active && m_k == m_nops)});
        check_eq("wr_ready", {31'h0, bus.wr_ready_o},    {31'h0, wr_rdy});
        check_eq("a_rdata", bus.a_rdata_o, m_buf[0][bus.rd_elem_i]);
        check_eq("b_rdata", bus.b_rdata_o, m_buf[1][bus.rd_elem_i]);
        check_eq("c_rdata", bus.c_rdata_o, m_buf[2][bus.rd_elem_i]);
        check_eq("mask", bus.mask_rdata_o, bus.is_mask_used_i ? m_mask : 32'h0);
        wfire = bus.wr_valid_i && wr_rdy;
        acc   = !m_active && bus.rd_req_i;
        wa = int'(bus.wr_addr_i); we = int'(bus.wr_elem_i);
        @(posedge clk_i);
        if (m_active) begin
            if (m_k == m_nops) m_active = 1'b0;
            else begin
                for (int e = 0; e < NE; e++) m_buf[m_k][e] = m_snap[m_k][e];
                m_k++;
            end
        end
        if (wfire) begin
            for (int b = 0; b < 4; b++) if (bus.wr_be_i[b]) begin
                m_mem[wa][we][8*b +: 8] = bus.wdata_i[8*b +: 8];
                if (wa == 0 && we == 0) m_mask[8*b +: 8] = bus.wdata_i[8*b +: 8];
            end
        end
        if (acc) begin
            nn = int'(bus.rd_nops_i);
            m_nops = (nn == 0) ? 1 : nn;
            m_addr[0] = int'(bus.a_addr_i);
            m_addr[1] = int'(bus.b_addr_i);
            m_addr[2] = int'(bus.c_addr_i);
            for (int i = 0; i < 3; i++) for (int e = 0; e < NE; e++)
                m_snap[i][e] = m_mem[m_addr[i]][e];
            m_active = 1'b1; m_k = 0;
        end
        #1;
    endtask

    task automatic write_beat(input int a, input int e, input logic [3:0] be, input logic [31:0] d);
        bus.wr_valid_i = 1'b1; bus.wr_addr_i = 5'(a); bus.wr_elem_i = 2'(e);
        bus.wr_be_i = be; bus.wdata_i = d;
        cycle();
        bus.wr_valid_i = 1'b0;
    endtask

    task automatic request(input int n, input int a, input int b, input int c);
        bus.rd_req_i = 1'b1; bus.rd_nops_i = 2'(n);
        bus.a_addr_i = 5'(a); bus.b_addr_i = 5'(b); bus.c_addr_i = 5'(c);
        cycle();
        bus.rd_req_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #12;
        check_eq("rst_busy",     {31'h0, bus.rd_busy_o},     32'h0);
        check_eq("rst_ready",    {31'h0, bus.rd_op_ready_o}, 32'h0);
        check_eq("rst_wr_ready", {31'h0, bus.wr_ready_o},    32'h1);
        check_eq("rst_mask",     bus.mask_rdata_o,           32'h0);
        @(negedge clk_i); resetn_i = 1'b1;

        // Byte-enabled partial write.
        write_beat(5, 2, 4'b1111, 32'hDEADBEEF);
        write_beat(5, 2, 4'b0001, 32'h00000011);

        // Three-operand capture: ready exactly three cycles after the accept edge.
        bus.rd_elem_i = 2'd2;
        request(3, 5, 6, 7);
        check_eq("t3_ready_early", {31'h0, bus.rd_op_ready_o}, 32'h0);
        cycle(); cycle(); cycle();
        check_eq("t3_ready", {31'h0, bus.rd_op_ready_o}, 32'h1);
        cycle();
        check_eq("t3_ready_gone", {31'h0, bus.rd_op_ready_o}, 32'h0);
        check_eq("t3_a_rdata", bus.a_rdata_o, 32'hDEADBE11);

        // Two operands: C buffer keeps the v7 contents even though C=9 holds data.
        write_beat(9, 2, 4'b1111, 32'h99999999);
        request(2, 5, 6, 9);
        cycle(); cycle();
        check_eq("t4_ready", {31'h0, bus.rd_op_ready_o}, 32'h1);
        cycle();
        check_eq("t4_busy_off", {31'h0, bus.rd_busy_o}, 32'h0);
        check_eq("t4_c_keep", bus.c_rdata_o, 32'h0);

        // Hazard: write to B held for CAP_A and CAP_B, lands afterwards.
        write_beat(4, 1, 4'b1111, 32'h01234567);
        bus.rd_elem_i = 2'd1;
        request(2, 3, 4, 0);
        bus.wr_valid_i = 1'b1; bus.wr_addr_i = 5'd4; bus.wr_elem_i = 2'd1;
        bus.wr_be_i = 4'b1111; bus.wdata_i = 32'hCAFEF00D;
        #1 check_eq("t5_hold1", {31'h0, bus.wr_ready_o}, 32'h0);
        cycle();
        check_eq("t5_hold2", {31'h0, bus.wr_ready_o}, 32'h0);
        cycle();
        check_eq("t5_go", {31'h0, bus.wr_ready_o}, 32'h1);
        cycle();
        bus.wr_valid_i = 1'b0;
        check_eq("t5_b_old", bus.b_rdata_o, 32'h01234567);
        request(1, 4, 0, 0);
        cycle(); cycle();
        check_eq("t5_landed", bus.a_rdata_o, 32'hCAFEF00D);

        // Mask shadow gating.
        write_beat(0, 0, 4'b1111, 32'hA5A5A5A5);
        bus.is_mask_used_i = 1'b1; #1;
        check_eq("t6_mask_on", bus.mask_rdata_o, 32'hA5A5A5A5);
        bus.is_mask_used_i = 1'b0; #1;
        check_eq("t6_mask_off", bus.mask_rdata_o, 32'h0);
        bus.is_mask_used_i = 1'b1;

        // Reset while in CAP_B.
        request(3, 5, 6, 7);
        cycle();
        #2 resetn_i = 1'b0;
        #1;
        model_reset();
        check_eq("t1_busy",     {31'h0, bus.rd_busy_o},     32'h0);
        check_eq("t1_ready",    {31'h0, bus.rd_op_ready_o}, 32'h0);
        check_eq("t1_wr_ready", {31'h0, bus.wr_ready_o},    32'h1);
        check_eq("t1_a",        bus.a_rdata_o,              32'h0);
        check_eq("t1_b",        bus.b_rdata_o,              32'h0);
        check_eq("t1_c",        bus.c_rdata_o,              32'h0);
        check_eq("t1_mask",     bus.mask_rdata_o,           32'h0);
        @(negedge clk_i); resetn_i = 1'b1;
        repeat (5) cycle();

        // Randomized traffic over a small address window so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            bus.rd_req_i       = ($urandom_range(0, 2) == 0);
            bus.rd_nops_i      = 2'($urandom_range(0, 3));
            bus.a_addr_i       = 5'($urandom_range(0, 7));
            bus.b_addr_i       = 5'($urandom_range(0, 7));
            bus.c_addr_i       = 5'($urandom_range(0, 7));
            bus.rd_elem_i      = 2'($urandom_range(0, 3));
            bus.wr_valid_i     = ($urandom_range(0, 1) == 1);
            bus.wr_addr_i      = 5'($urandom_range(0, 7));
            bus.wr_elem_i      = 2'($urandom_range(0, 3));
            bus.wr_be_i        = 4'($urandom_range(0, 15));
            bus.wdata_i        = $urandom;
            bus.is_mask_used_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
